// File: rtl/joy_db15_pkg.sv
// Shared constants, state type and helpers for the DB15 joystick adapter (transmitter and receiver).
package joy_db15_pkg;

    localparam int JOY_DB15_NBITS = 16;
    localparam int FRAME_BITS     = 2 * JOY_DB15_NBITS;
    localparam int CNT_W          = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } db15_tx_state_t;

    // Button bit positions within a player word, shared with the host receiver
    localparam int BTN_R = 0;
    localparam int BTN_L = 1;
    localparam int BTN_D = 2;
    localparam int BTN_U = 3;
    localparam int BTN_A = 4;
    localparam int BTN_B = 5;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/joy_db15_sync.sv
// Input conditioner: synchroniser chain, optional 3-sample majority filter
// (JOY_DB15_TX_FILTER_EN), registered level and rising-edge outputs.
module joy_db15_sync
    import joy_db15_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   clean_s;
    logic                   level_r;
    logic                   rise_r;

    // Metastability chain; resets high to match the idle-high lines
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

`ifdef JOY_DB15_TX_FILTER_EN
    logic [1:0] hist_r;
    logic       filt_r;

    // Majority over three consecutive samples; a single-clk glitch never wins the vote
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_r <= 2'b11;
            filt_r <= 1'b1;
        end else begin
            hist_r <= {hist_r[0], sync_r[SYNC_STAGES-1]};
            filt_r <= maj3(sync_r[SYNC_STAGES-1], hist_r[0], hist_r[1]);
        end
    end

    assign clean_s = filt_r;
`else
    assign clean_s = sync_r[SYNC_STAGES-1];
`endif

    // Level and edge are registered together so load and shift stay cycle-aligned
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_r <= 1'b1;
            rise_r  <= 1'b0;
        end else begin
            level_r <= clean_s;
            rise_r  <= clean_s & ~level_r;
        end
    end

    assign level = level_r;
    assign rise  = rise_r;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick adapter emulation (chained 74x165 pair seen from the pins).
// Optional input glitch filter: define JOY_DB15_TX_FILTER_EN.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int NBITS       = JOY_DB15_NBITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            joy_clk_in,
    input  logic                            joy_load_in,
    input  logic [NBITS-1:0]                joystick1,
    input  logic [NBITS-1:0]                joystick2,
    output logic                            joy_data,
    output logic                            frame_done,
    output logic                            overrun,
    output logic [$clog2(2*NBITS+1)-1:0]    bit_cnt
);

    localparam int FB = 2 * NBITS;
    localparam int CW = $clog2(FB + 1);

    logic           ld_s;
    logic           ld_rise_s;
    logic           clk_level_s;
    logic           clk_rise_s;
    db15_tx_state_t state_s;

    logic [FB-1:0]  shreg_r, shreg_nx_s;
    logic [CW-1:0]  cnt_r, cnt_nx_s;
    logic           ovr_r, ovr_nx_s;
    logic           done_r, done_nx_s;
    logic           data_r;

    joy_db15_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ld (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (joy_load_in),
        .level   (ld_s),
        .rise    (ld_rise_s)
    );

    joy_db15_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (joy_clk_in),
        .level   (clk_level_s),
        .rise    (clk_rise_s)
    );

    // State is implied by the load level and how far the frame has shifted
    always_comb begin
        if (!ld_s) begin
            state_s = ST_LOAD;
        end else if (cnt_r < CW'(FB)) begin
            state_s = ST_SHIFT;
        end else begin
            state_s = ST_DRAIN;
        end
    end

    // Next-state logic; load has priority over a coincident shift edge
    always_comb begin
        shreg_nx_s = shreg_r;
        cnt_nx_s   = cnt_r;
        ovr_nx_s   = ovr_r;
        done_nx_s  = 1'b0;
        case (state_s)
            ST_LOAD: begin
                shreg_nx_s = {joystick2, joystick1};
                cnt_nx_s   = {CW{1'b0}};
                ovr_nx_s   = 1'b0;
            end
            ST_SHIFT: begin
                if (clk_rise_s) begin
                    shreg_nx_s = {1'b0, shreg_r[FB-1:1]};
                    cnt_nx_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    done_nx_s  = (cnt_r == CW'(FB - 2));
                end else begin
                    shreg_nx_s = shreg_r;
                end
            end
            ST_DRAIN: begin
                if (clk_rise_s) begin
                    shreg_nx_s = {FB{1'b0}};
                    ovr_nx_s   = 1'b1;
                end else begin
                    ovr_nx_s   = ovr_r;
                end
            end
            default: begin
                shreg_nx_s = {FB{1'b0}};
                cnt_nx_s   = {CW{1'b0}};
                ovr_nx_s   = 1'b0;
            end
        endcase
    end

    // State and output flops; joy_data registers the next LSB so it moves with the shift
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_r <= {FB{1'b0}};
            cnt_r   <= {CW{1'b0}};
            ovr_r   <= 1'b0;
            done_r  <= 1'b0;
            data_r  <= 1'b1;
        end else begin
            shreg_r <= shreg_nx_s;
            cnt_r   <= cnt_nx_s;
            ovr_r   <= ovr_nx_s;
            done_r  <= done_nx_s;
            data_r  <= ~shreg_nx_s[0];
        end
    end

    assign joy_data   = data_r;
    assign frame_done = done_r;
    assign overrun    = ovr_r;
    assign bit_cnt    = cnt_r;

    logic unused_s;
    assign unused_s = ld_rise_s ^ clk_level_s;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed, table-driven bench for joy_db15_tx acting as the DB15 host.
module tb_joy_db15_tx;

    logic        clk;
    logic        reset_n;
    logic        joy_clk_in;
    logic        joy_load_in;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        joy_data;
    logic        frame_done;
    logic        overrun;
    logic [5:0]  bit_cnt;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    joy_db15_tx dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .joy_clk_in  (joy_clk_in),
        .joy_load_in (joy_load_in),
        .joystick1   (joystick1),
        .joystick2   (joystick2),
        .joy_data    (joy_data),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .bit_cnt     (bit_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [15:0] j1;
        logic [15:0] j2;
        int          n;
        logic [31:0] exp_samp;
        logic [5:0]  exp_cnt;
        logic        exp_ovr;
        int          exp_done;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_clock();
        joy_clk_in = 1'b1;
        wait_clk(8);
        joy_clk_in = 1'b0;
        wait_clk(8);
    endtask

    // Load for 10 clk, release, then n host clocks sampling before each rising edge
    task automatic run_frame(input logic [15:0] j1, input logic [15:0] j2, input int n,
                             output logic [31:0] samp, output int dones);
        int d0;
        joystick1   = j1;
        joystick2   = j2;
        joy_load_in = 1'b0;
        wait_clk(10);
        chk("load_cnt", {26'd0, bit_cnt}, 32'd0);
        chk("load_ovr", {31'd0, overrun}, 32'd0);
        chk("load_data", {31'd0, joy_data}, {31'd0, ~j1[0]});
        joy_load_in = 1'b1;
        wait_clk(8);
        d0   = done_cnt;
        samp = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            if (i < 32) samp[i] = joy_data;
            host_clock();
        end
        dones = done_cnt - d0;
    endtask

    initial begin
        logic [31:0] samp;
        int          dones;
        int          d0;
        logic [15:0] rj1, rj2;

        vecs[0] = '{16'h0015, 16'h8002, 32, 32'h7FFD_FFEA, 6'd32, 1'b0, 1};
        vecs[1] = '{16'h0015, 16'h8002, 34, 32'h7FFD_FFEA, 6'd32, 1'b1, 1};
        vecs[2] = '{16'hFFFF, 16'h0000, 32, 32'hFFFF_0000, 6'd32, 1'b0, 1};
        vecs[3] = '{16'hA5A5, 16'h3C3C, 32, 32'hC3C3_5A5A, 6'd32, 1'b0, 1};
        vecs[4] = '{16'h0001, 16'h0000, 20, 32'hFFFF_FFFE, 6'd20, 1'b0, 0};
        vecs[5] = '{16'h0000, 16'h0000, 31, 32'hFFFF_FFFF, 6'd31, 1'b0, 1};

        // Reset held with pins toggling
        reset_n     = 1'b0;
        joy_clk_in  = 1'b0;
        joy_load_in = 1'b1;
        joystick1   = 16'h00FF;
        joystick2   = 16'hFF00;
        for (int i = 0; i < 6; i++) begin
            joy_clk_in  = ~joy_clk_in;
            joy_load_in = (i % 3 != 0);
            wait_clk(2);
            chk("rst_data", {31'd0, joy_data}, 32'd1);
            chk("rst_cnt", {26'd0, bit_cnt}, 32'd0);
            chk("rst_ovr", {31'd0, overrun}, 32'd0);
        end
        joy_clk_in  = 1'b0;
        joy_load_in = 1'b1;
        wait_clk(1);
        reset_n = 1'b1;
        wait_clk(6);

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].j1, vecs[v].j2, vecs[v].n, samp, dones);
            chk($sformatf("v%0d_samples", v), samp, vecs[v].exp_samp);
            chk($sformatf("v%0d_cnt", v), {26'd0, bit_cnt}, {26'd0, vecs[v].exp_cnt});
            chk($sformatf("v%0d_ovr", v), {31'd0, overrun}, {31'd0, vecs[v].exp_ovr});
            chk($sformatf("v%0d_done", v), dones, vecs[v].exp_done);
            if (vecs[v].n >= 32) chk($sformatf("v%0d_idle", v), {31'd0, joy_data}, 32'd1);
        end

        // Abort: load re-asserted after 7 shifts
        run_frame(16'h0035, 16'h1234, 7, samp, dones);
        chk("abort_pre_cnt", {26'd0, bit_cnt}, 32'd7);
        d0 = done_cnt;
        joy_load_in = 1'b0;
        wait_clk(6);
        chk("abort_cnt", {26'd0, bit_cnt}, 32'd0);
        chk("abort_data", {31'd0, joy_data}, 32'd0);

        // Collision: host clock edge while load is low, buttons change meanwhile
        joystick1  = 16'h0034;
        joy_clk_in = 1'b1;
        wait_clk(8);
        chk("coll_cnt", {26'd0, bit_cnt}, 32'd0);
        chk("coll_data", {31'd0, joy_data}, 32'd1);
        joy_clk_in = 1'b0;
        wait_clk(8);
        chk("abort_done", done_cnt - d0, 32'd0);
        joy_load_in = 1'b1;
        wait_clk(8);
        host_clock();
        chk("post_coll_cnt", {26'd0, bit_cnt}, 32'd1);

        // Reset mid-frame: async clear, then joy_data idles high without a load
        run_frame(16'h0000, 16'h0000, 10, samp, dones);
        chk("mid_pre_cnt", {26'd0, bit_cnt}, 32'd10);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_cnt", {26'd0, bit_cnt}, 32'd0);
        chk("mid_rst_data", {31'd0, joy_data}, 32'd1);
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(6);
        for (int i = 0; i < 3; i++) host_clock();
        chk("mid_after_data", {31'd0, joy_data}, 32'd1);
        chk("mid_after_cnt", {26'd0, bit_cnt}, 32'd3);

        // Random words through the host-side model
        for (int r = 0; r < 6; r++) begin
            rj1 = 16'($urandom);
            rj2 = 16'($urandom);
            run_frame(rj1, rj2, 32, samp, dones);
            chk($sformatf("rnd%0d_samples", r), samp, ~{rj2, rj1});
            chk($sformatf("rnd%0d_done", r), dones, 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
